// File: rtl/gbe_oflow_status_ctrl.sv
// gbe_oflow_status_ctrl
// Gathers overflow levels from the 10GbE transmit cores. For each source it keeps
// a sticky flag and a saturating rising-edge counter. It drives one source's counter
// onto the 32-bit software status word, with the source picked by software or by a
// round-robin scan. A 4-phase req/ack handshake clears the counters and stickies.
//
// Clear handshake states:
//   state   | meaning
//   S_IDLE  | waiting for clr_req
//   S_CLEAR | one cycle: counters and stickies reload from this cycle's inputs
//   S_ACK   | clr_ack high, waiting for clr_req to drop
module gbe_oflow_status_ctrl #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16,
    parameter int DWELL = 1024
) (
    input  logic             i_user_clk,
    input  logic             i_user_rst_n,
    input  logic [N_SRC-1:0] i_oflow_in,
    input  logic             i_auto_scan,
    input  logic [2:0]       i_sel,
    input  logic             i_clr_req,
    output logic             o_clr_ack,
    output logic [31:0]      o_status_word
);

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [2:0]      IDX_LAST   = 3'(N_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACK   = 2'd2
    } clr_state_t;

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic              w_clear;
    logic              w_clr_ack;

    logic [N_SRC-1:0]  r_prev;
    logic [N_SRC-1:0]  r_sticky;
    logic [CNT_W-1:0]  r_cnt [N_SRC];
    logic [N_SRC-1:0]  w_evt;

    logic [DW_W-1:0]   r_dwell;
    logic [2:0]        r_scan_idx;
    logic [2:0]        w_idx;
    logic [15:0]       w_sel_cnt;
    logic [31:0]       w_status;
    logic [31:0]       r_status;

    // r_prev resets to 0, so a source that is already high right after reset counts as one event.
    assign w_evt = i_oflow_in & ~r_prev;
    assign w_idx = i_auto_scan ? r_scan_idx : i_sel;

    // Clear handshake state register.
    always_ff @(posedge i_user_clk or negedge i_user_rst_n) begin
        if (!i_user_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the clear handshake. Ack depends only on the state, so reset drops it at once.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_clr_ack   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_clr_req) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_clear     = 1'b1;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_clr_ack = 1'b1;
                if (!i_clr_req) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_clr_ack = w_clr_ack;

    // Edge history, saturating counters and sticky flags. During a clear they reload from this cycle's inputs, so no event is lost.
    always_ff @(posedge i_user_clk or negedge i_user_rst_n) begin
        if (!i_user_rst_n) begin
            r_prev   <= '0;
            r_sticky <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_prev   <= i_oflow_in;
            r_sticky <= w_clear ? i_oflow_in : (r_sticky | i_oflow_in);
            for (int i = 0; i < N_SRC; i++) begin
                if (w_clear) begin
                    r_cnt[i] <= w_evt[i] ? CNT_W'(1) : '0;
                end else if (w_evt[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Round-robin dwell timer. Leaving auto-scan parks it at source 0, so re-entry starts there.
    always_ff @(posedge i_user_clk or negedge i_user_rst_n) begin
        if (!i_user_rst_n) begin
            r_dwell    <= '0;
            r_scan_idx <= '0;
        end else if (!i_auto_scan) begin
            r_dwell    <= '0;
            r_scan_idx <= '0;
        end else if (r_dwell == DWELL_LAST) begin
            r_dwell    <= '0;
            r_scan_idx <= (r_scan_idx == IDX_LAST) ? 3'd0 : r_scan_idx + 3'd1;
        end else begin
            r_dwell <= r_dwell + DW_W'(1);
        end
    end

    // Assemble the status word. An index with no matching source shows a zero count.
    always_comb begin
        w_sel_cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_idx == 3'(i)) w_sel_cnt = 16'(r_cnt[i]);
        end
        w_status              = '0;
        w_status[31]          = |r_sticky;
        w_status[30:28]       = w_idx;
        w_status[20 +: N_SRC] = r_sticky;
        w_status[15:0]        = w_sel_cnt;
    end

    // Register the status word, one cycle behind the counter and sticky state.
    always_ff @(posedge i_user_clk or negedge i_user_rst_n) begin
        if (!i_user_rst_n) begin
            r_status <= '0;
        end else begin
            r_status <= w_status;
        end
    end

    assign o_status_word = r_status;

endmodule

// File: tb/tb_gbe_oflow_status_ctrl.sv
// Bench for gbe_oflow_status_ctrl: directed vectors. A behavioural model is checked every cycle, and hand-computed literals pin the model.
module tb_gbe_oflow_status_ctrl;

    localparam int N     = 4;
    localparam int CW    = 12;
    localparam int DW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [N-1:0] oflow = '0;
    logic        auto_scan = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        clr_req = 1'b0;
    logic        clr_ack;
    logic [31:0] status;

    int checks = 0;
    int failures = 0;

    gbe_oflow_status_ctrl #(.N_SRC(N), .CNT_W(CW), .DWELL(DW)) dut (
        .i_user_clk    (clk),
        .i_user_rst_n  (rst_n),
        .i_oflow_in    (oflow),
        .i_auto_scan   (auto_scan),
        .i_sel         (sel),
        .i_clr_req     (clr_req),
        .o_clr_ack     (clr_ack),
        .o_status_word (status)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_cnt [N];
    bit [N-1:0]  m_stk;
    bit [N-1:0]  m_prev;
    int          m_scan;
    int          m_cycle;      // cycles spent in auto-scan since last entry
    int          m_phase;      // 0 waiting, 1 clearing, 2 acknowledging
    bit [31:0]   m_status;
    int          m_idx;
    bit          m_evt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_stk = '0; m_prev = '0; m_scan = 0; m_cycle = 0; m_phase = 0; m_status = '0;
        end else begin
            m_idx = auto_scan ? m_scan : int'(sel);
            m_status = '0;
            m_status[31] = |m_stk;
            m_status[30:28] = m_idx[2:0];
            m_status[23:20] = m_stk;
            if (m_idx < N) m_status[15:0] = m_cnt[m_idx][15:0];
            for (int i = 0; i < N; i++) begin
                m_evt = oflow[i] && !m_prev[i];
                if (m_phase == 1) begin
                    m_cnt[i] = m_evt ? 1 : 0;
                    m_stk[i] = oflow[i];
                end else begin
                    if (m_evt && m_cnt[i] < MAXC) m_cnt[i] = m_cnt[i] + 1;
                    if (oflow[i]) m_stk[i] = 1'b1;
                end
            end
            m_prev = oflow;
            if (m_phase == 0 && clr_req) m_phase = 1;
            else if (m_phase == 1) m_phase = 2;
            else if (m_phase == 2 && !clr_req) m_phase = 0;
            if (!auto_scan) begin
                m_scan = 0; m_cycle = 0;
            end else begin
                m_cycle = m_cycle + 1;
                m_scan = (m_cycle / DW) % N;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_status", status, m_status);
        check("model_ack", {31'd0, clr_ack}, {31'd0, m_phase == 2});
    end

    task automatic pulse(input int s);
        oflow[s] = 1'b1;
        @(negedge clk);
        oflow[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clr_req = 1'b1;
        repeat (3) @(negedge clk);
        clr_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_status", status, 32'h0000_0000);
        check("reset_ack", {31'd0, clr_ack}, 32'd0);

        // Source 2 counted twice, viewed through sel=2.
        sel = 3'd2;
        oflow[2] = 1'b1;
        repeat (3) @(negedge clk);
        oflow[2] = 1'b0;
        @(negedge clk);
        oflow[2] = 1'b1;
        @(negedge clk);
        oflow[2] = 1'b0;
        @(negedge clk);
        check("sel2_count2", status, 32'hA040_0002);

        // Selecting an index with no source gives a zero count field.
        sel = 3'd4;
        @(negedge clk);
        check("sel_out_of_range", status, 32'hC040_0000);

        // Clear with a rising edge in the CLEAR cycle and an event during ACK.
        sel = 3'd1;
        clr_req = 1'b1;
        @(negedge clk);
        oflow[1] = 1'b1;
        @(negedge clk);
        oflow[1] = 1'b0;
        check("ack_raised", {31'd0, clr_ack}, 32'd1);
        repeat (3) @(negedge clk);
        oflow[3] = 1'b1;
        @(negedge clk);
        oflow[3] = 1'b0;
        repeat (4) @(negedge clk);
        check("ack_held", {31'd0, clr_ack}, 32'd1);
        clr_req = 1'b0;
        @(negedge clk);
        check("ack_dropped", {31'd0, clr_ack}, 32'd0);
        @(negedge clk);
        check("after_clear_src1", status, 32'h90A0_0001);
        sel = 3'd3;
        @(negedge clk);
        check("after_clear_src3", status, 32'hB0A0_0001);

        // Saturation of source 0.
        do_clear();
        sel = 3'd0;
        @(negedge clk);
        check("cleared_all", status, 32'h0000_0000);
        for (int k = 0; k < MAXC + 500; k++) pulse(0);
        check("saturated", status, 32'h8010_0FFF);

        // Auto-scan over counts 1,2,3,4.
        do_clear();
        for (int s = 0; s < N; s++)
            for (int k = 0; k <= s; k++) pulse(s);
        auto_scan = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= N; k++) begin
            check("scan_step", status,
                  32'h80F0_0000 | (32'(k % N) << 28) | 32'((k % N) + 1));
            repeat (DW) @(negedge clk);
        end
        auto_scan = 1'b0;
        sel = 3'd3;
        repeat (2) @(negedge clk);
        check("manual_after_scan", status, 32'hB0F0_0004);

        // Reset in the middle of a handshake, with clr_req still high afterwards.
        clr_req = 1'b1;
        repeat (3) @(negedge clk);
        check("ack_before_reset", {31'd0, clr_ack}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ack", {31'd0, clr_ack}, 32'd0);
        check("async_status", status, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reclear_phase", {31'd0, clr_ack}, 32'd0);
        @(negedge clk);
        check("reclear_ack", {31'd0, clr_ack}, 32'd1);
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        check("final_ack", {31'd0, clr_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
